// File: rtl/adc_fifo_pkg.sv
// adc_fifo_pkg: shared types and sizing for the ADC sample FIFO.
//   SAMPLE_WIDTH : width of one ADC sample word
//   FIFO_DEPTH   : default number of buffered sample words
//   sample_t     : one ADC sample word
package adc_fifo_pkg;

  localparam int SAMPLE_WIDTH = 64;
  localparam int FIFO_DEPTH   = 16;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;

endpackage : adc_fifo_pkg

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port synchronous RAM, one write port and one
// registered read port, shaped so synthesis maps it onto block RAM.
//   clk   : clock
//   rst   : synchronous active-high reset of the read data register only
//   we    : write enable; wdata is stored at waddr
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata loads mem[raddr]
//   raddr : read address
//   rdata : registered read data (read-first when raddr == waddr)
module fifo_ram
  import adc_fifo_pkg::*;
#(
  parameter  int WIDTH = SAMPLE_WIDTH,
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; resetting it would prevent
  // block-RAM inference and the FIFO never exposes unwritten words anyway.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks, so every register
    // samples pre-edge values regardless of block evaluation order.
    if (we) mem[waddr] <= wdata;
  end

  // Output register with synchronous reset, as supported by BRAM primitives.
  // A same-address read and write returns the old word (read-first), which
  // is what the FIFO relies on when reading and writing while full.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule : fifo_ram

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: single-clock FIFO for 64-bit ADC samples with separate
// write-side and read-side status flags. Normal (non show-ahead) read mode:
// q holds the popped word one cycle after an accepted rdreq.
//   clk     : clock, all state updates on the rising edge
//   clear   : synchronous active-high reset, empties the FIFO, q -> 0
//   data    : write data
//   wrreq   : write request
//   wrfull  : write-side full flag
//   wrempty : write-side empty flag
//   q       : registered read data
//   rdreq   : read request
//   rdempty : read-side empty flag
//   rdfull  : read-side full flag
//   usedw   : number of stored words, 0..DEPTH
module adc_sample_fifo
  import adc_fifo_pkg::*;
#(
  parameter  int WIDTH = SAMPLE_WIDTH,
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] data,
  input  logic             wrreq,
  output logic             wrfull,
  output logic             wrempty,
  output logic [WIDTH-1:0] q,
  input  logic             rdreq,
  output logic             rdempty,
  output logic             rdfull,
  output logic [AW:0]      usedw
);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  logic empty;
  logic full;
  logic rd_ok;
  logic wr_ok;
  logic wr_en;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A read frees a slot in the same cycle, so a write while full is still
  // accepted when paired with a read. A read while empty is rejected, so
  // there is no write-to-read bypass.
  assign rd_ok = rdreq && !empty;
  assign wr_ok = wrreq && (!full || rd_ok);
  assign wr_en = wr_ok && !clear;

  assign wrempty = empty;
  assign rdempty = empty;
  assign wrfull  = full;
  assign rdfull  = full;
  assign usedw   = count;

  always_ff @(posedge clk) begin
    if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (clear),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (data),
    .re    (rd_ok),
    .raddr (rptr),
    .rdata (q)
  );

endmodule : adc_sample_fifo

// File: tb/tb_adc_sample_fifo.sv
// tb_adc_sample_fifo: directed bench for adc_sample_fifo. A queue-based
// model tracks FIFO contents and the expected q; a compare process checks
// every DUT output against it on each falling edge, and directed steps add
// hand-computed literal expectations.
module tb_adc_sample_fifo;
  import adc_fifo_pkg::*;

  localparam int DEPTH = FIFO_DEPTH;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          clear;
  sample_t       data;
  logic          wrreq;
  logic          rdreq;
  logic          wrfull;
  logic          wrempty;
  logic          rdempty;
  logic          rdfull;
  sample_t       q;
  logic [AW:0]   usedw;

  int n_cmp  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  sample_t mq[$];
  sample_t model_q;

  always #5 clk = ~clk;

  adc_sample_fifo dut (
    .clk     (clk),
    .clear   (clear),
    .data    (data),
    .wrreq   (wrreq),
    .wrfull  (wrfull),
    .wrempty (wrempty),
    .q       (q),
    .rdreq   (rdreq),
    .rdempty (rdempty),
    .rdfull  (rdfull),
    .usedw   (usedw)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a queue of stored words plus the last popped word.
  always @(posedge clk) begin
    bit rd;
    bit wr;
    if (clear) begin
      mq.delete();
      model_q = '0;
    end else begin
      rd = rdreq && (mq.size() > 0);
      wr = wrreq && ((mq.size() < DEPTH) || rd);
      if (rd) model_q = mq.pop_front();
      if (wr) mq.push_back(data);
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      check("m_usedw",   64'(usedw),   64'(mq.size()));
      check("m_wrempty", 64'(wrempty), 64'(mq.size() == 0));
      check("m_rdempty", 64'(rdempty), 64'(mq.size() == 0));
      check("m_wrfull",  64'(wrfull),  64'(mq.size() == DEPTH));
      check("m_rdfull",  64'(rdfull),  64'(mq.size() == DEPTH));
      check("m_q",       q,            model_q);
    end
  end

  // Apply inputs for one rising edge, return 1 time unit after it.
  task automatic drive(input logic w, input logic r, input sample_t d);
    wrreq = w;
    rdreq = r;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear = 1'b1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    data  = '0;

    // 1. Reset
    drive(0, 0, '0);
    drive(0, 0, '0);
    checking = 1'b1;
    check("rst_rdempty", 64'(rdempty), 64'd1);
    check("rst_wrempty", 64'(wrempty), 64'd1);
    check("rst_rdfull",  64'(rdfull),  64'd0);
    check("rst_wrfull",  64'(wrfull),  64'd0);
    check("rst_usedw",   64'(usedw),   64'd0);
    check("rst_q",       q,            64'd0);
    clear = 1'b0;

    // 2. Burst write of constant data
    for (int i = 0; i < 4; i++) drive(1, 0, 64'hF);
    drive(0, 0, '0);
    check("burst_usedw",   64'(usedw),   64'd4);
    check("burst_wrempty", 64'(wrempty), 64'd0);
    check("burst_rdfull",  64'(rdfull),  64'd0);

    // 3. Drain with one extra read
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, '0);
      check("drain_q",     q,          64'hF);
      check("drain_usedw", 64'(usedw), 64'(3 - i));
    end
    drive(0, 1, '0);
    check("drain_hold_q",  q,            64'hF);
    check("drain_rdempty", 64'(rdempty), 64'd1);
    check("drain_usedw0",  64'(usedw),   64'd0);
    drive(0, 0, '0);

    // 4. Fill and overflow
    for (int i = 0; i <= 16; i++) drive(1, 0, sample_t'(i));
    drive(0, 0, '0);
    check("full_wrfull", 64'(wrfull), 64'd1);
    check("full_rdfull", 64'(rdfull), 64'd1);
    check("full_usedw",  64'(usedw),  64'd16);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, '0);
      check("full_drain_q", q, 64'(i));
    end
    drive(0, 1, '0);
    check("no_16_q",       q,            64'd15);
    check("no_16_rdempty", 64'(rdempty), 64'd1);

    // 5. Wrap and simultaneous access
    for (int i = 0; i < 10; i++) drive(1, 0, sample_t'(100 + i));
    for (int i = 0; i < 10; i++) drive(0, 1, '0);
    check("wrap_q_109", q, 64'd109);
    for (int i = 0; i < 12; i++) drive(1, 0, sample_t'(64'hA0 + i));
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, sample_t'(64'hB0 + i));
      check("rw_usedw", 64'(usedw), 64'd12);
      check("rw_q",     q,          64'hA0 + 64'(i));
    end
    for (int i = 4; i < 12; i++) begin
      drive(0, 1, '0);
      check("wrap_q_a", q, 64'hA0 + 64'(i));
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, '0);
      check("wrap_q_b", q, 64'hB0 + 64'(i));
    end
    check("wrap_empty", 64'(rdempty), 64'd1);

    // read and write together while full
    for (int i = 0; i < 16; i++) drive(1, 0, sample_t'(64'hC0 + i));
    drive(1, 1, 64'hD0);
    check("fullrw_usedw", 64'(usedw),  64'd16);
    check("fullrw_q",     q,           64'hC0);
    check("fullrw_full",  64'(wrfull), 64'd1);
    for (int i = 1; i < 16; i++) begin
      drive(0, 1, '0);
      check("fullrw_drain", q, 64'hC0 + 64'(i));
    end
    drive(0, 1, '0);
    check("fullrw_d0", q, 64'hD0);

    // read and write together while empty: write only
    drive(1, 1, 64'hE0);
    check("emptyrw_usedw", 64'(usedw), 64'd1);
    check("emptyrw_q",     q,          64'hD0);
    drive(0, 1, '0);
    check("emptyrw_read",  q,          64'hE0);

    // 6. Reset mid-operation
    for (int i = 0; i < 5; i++) drive(1, 0, sample_t'(64'hF0 + i));
    clear = 1'b1;
    drive(0, 1, '0);
    clear = 1'b0;
    check("mid_usedw",   64'(usedw),   64'd0);
    check("mid_rdempty", 64'(rdempty), 64'd1);
    check("mid_q",       q,            64'd0);
    drive(1, 0, 64'h1234);
    drive(0, 1, '0);
    check("post_q",     q,          64'h1234);
    check("post_usedw", 64'(usedw), 64'd0);
    drive(0, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_adc_sample_fifo
